// File: rtl/vedic_mult4_pipe.sv
// Two-stage pipelined 4x4 unsigned Urdhva-Tiryakbhyam multiplier with
// valid/ready handshakes; S1 holds 2x2 partial products, S2 holds the product.
module vedic_mult4_pipe (
    input  logic       CP,
    input  logic       R_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] p,
    output logic       busy
);

    localparam int unsigned OP_W  = 4;
    localparam int unsigned PP_W  = 4;
    localparam int unsigned MID_W = 6;
    localparam int unsigned P_W   = 2 * OP_W;

    // 2x2 cell: vertical and crosswise AND terms combined with two half adders
    function automatic logic [PP_W-1:0] vedic2x2(input logic [1:0] x, input logic [1:0] y);
        logic t_lo, t_x1, t_x2, t_hi, c1;
        logic [PP_W-1:0] r;
        t_lo = x[0] & y[0];
        t_x1 = x[1] & y[0];
        t_x2 = x[0] & y[1];
        t_hi = x[1] & y[1];
        c1   = t_x1 & t_x2;
        r[0] = t_lo;
        r[1] = t_x1 ^ t_x2;
        r[2] = t_hi ^ c1;
        r[3] = t_hi & c1;
        return r;
    endfunction

    logic [PP_W-1:0]  pp0, pp1, pp2, pp3;
    logic             s1_valid;
    logic             s2_free;
    logic             accept;
    logic             advance;
    logic [MID_W-1:0] mid_sum;
    logic [P_W-1:0]   p_sum;

    assign s2_free  = !out_valid | out_ready;
    assign in_ready = !s1_valid | s2_free;
    assign accept   = in_valid & in_ready;
    assign advance  = s1_valid & s2_free;
    assign busy     = s1_valid | out_valid;

    // Crosswise terms share weight 4; the top term carries weight 16
    assign mid_sum = MID_W'(pp1) + MID_W'(pp2);
    assign p_sum   = P_W'(pp0) + P_W'({mid_sum, 2'b00}) + P_W'({pp3, 4'b0000});

    always_ff @(posedge CP or negedge R_n) begin
        if (!R_n) begin
            pp0      <= '0;
            pp1      <= '0;
            pp2      <= '0;
            pp3      <= '0;
            s1_valid <= 1'b0;
        end else begin
            if (accept) begin
                pp0 <= vedic2x2(a[1:0], b[1:0]);
                pp1 <= vedic2x2(a[3:2], b[1:0]);
                pp2 <= vedic2x2(a[1:0], b[3:2]);
                pp3 <= vedic2x2(a[3:2], b[3:2]);
            end
            s1_valid <= accept | (s1_valid & !s2_free);
        end
    end

    // p only changes on an S1 -> S2 transfer, so it holds under backpressure and when idle
    always_ff @(posedge CP or negedge R_n) begin
        if (!R_n) begin
            p         <= '0;
            out_valid <= 1'b0;
        end else begin
            if (advance) begin
                p <= p_sum;
            end
            out_valid <= advance | (out_valid & !out_ready);
        end
    end

endmodule

// File: tb/tb_vedic_mult4_pipe.sv
// Directed and exhaustive scoreboard bench for vedic_mult4_pipe.
module tb_vedic_mult4_pipe;

    logic       CP;
    logic       R_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] p;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int pops     = 0;

    logic [7:0] sb[$];
    logic       last_acc;
    logic       last_in_ready;

    vedic_mult4_pipe dut (
        .CP       (CP),
        .R_n      (R_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .p        (p),
        .busy     (busy)
    );

    initial begin
        CP = 1'b0;
        forever #5 CP = ~CP;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, score handshakes, then take the rising edge
    task automatic cyc(input logic v, input logic [3:0] ta, input logic [3:0] tb_, input logic r);
        logic [7:0] exp;
        logic [7:0] xa;
        logic [7:0] xb;
        @(negedge CP);
        in_valid  = v;
        a         = ta;
        b         = tb_;
        out_ready = r;
        #1;
        last_in_ready = in_ready;
        last_acc      = in_valid & in_ready;
        if (out_valid & out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", 8'(out_valid), 8'h00);
            end else begin
                exp = sb.pop_front();
                chk("p_order", p, exp);
                pops++;
            end
        end
        if (last_acc) begin
            xa = 8'(ta);
            xb = 8'(tb_);
            sb.push_back(8'(xa * xb));
        end
        @(posedge CP);
    endtask

    initial begin
        int idx;
        int budget;

        R_n       = 1'b1;
        in_valid  = 1'b0;
        a         = 4'h0;
        b         = 4'h0;
        out_ready = 1'b0;

        // Reset asserted before any clock edge
        #2 R_n = 1'b0;
        #1;
        chk("rst_out_valid", 8'(out_valid), 8'h00);
        chk("rst_p", p, 8'h00);
        chk("rst_busy", 8'(busy), 8'h00);
        chk("rst_in_ready", 8'(in_ready), 8'h01);
        repeat (2) @(posedge CP);
        @(negedge CP);
        R_n = 1'b1;

        // Single operation
        cyc(1'b1, 4'hF, 4'hF, 1'b1);
        #1 chk("single_s1_no_out", 8'(out_valid), 8'h00);
        cyc(1'b0, 4'h0, 4'h0, 1'b1);
        #1;
        chk("single_valid", 8'(out_valid), 8'h01);
        chk("single_p", p, 8'hE1);
        cyc(1'b0, 4'h0, 4'h0, 1'b1);
        #1;
        chk("single_valid_drop", 8'(out_valid), 8'h00);
        chk("single_busy", 8'(busy), 8'h00);
        chk("single_p_hold", p, 8'hE1);

        // Streaming at full rate
        pops = 0;
        cyc(1'b1, 4'd3, 4'd5, 1'b1);
        chk("stream_in_ready0", 8'(last_in_ready), 8'h01);
        cyc(1'b1, 4'd9, 4'd7, 1'b1);
        chk("stream_in_ready1", 8'(last_in_ready), 8'h01);
        #1 chk("stream_p0", p, 8'h0F);
        cyc(1'b1, 4'd12, 4'd10, 1'b1);
        chk("stream_in_ready2", 8'(last_in_ready), 8'h01);
        #1 chk("stream_p1", p, 8'h3F);
        cyc(1'b1, 4'd0, 4'd13, 1'b1);
        chk("stream_in_ready3", 8'(last_in_ready), 8'h01);
        #1 chk("stream_p2", p, 8'h78);
        cyc(1'b0, 4'h0, 4'h0, 1'b1);
        #1 chk("stream_p3", p, 8'h00);
        cyc(1'b0, 4'h0, 4'h0, 1'b1);
        chk("stream_pops", 8'(pops), 8'd4);

        // Backpressure: two in flight, then release in order
        cyc(1'b1, 4'd6, 4'd6, 1'b0);
        chk("bp_in_ready_first", 8'(last_in_ready), 8'h01);
        cyc(1'b1, 4'd15, 4'd2, 1'b0);
        chk("bp_accept_second", 8'(last_acc), 8'h01);
        #1;
        chk("bp_in_ready_low", 8'(in_ready), 8'h00);
        chk("bp_out_valid", 8'(out_valid), 8'h01);
        chk("bp_p", p, 8'h24);
        cyc(1'b1, 4'd1, 4'd1, 1'b0);
        chk("bp_no_accept", 8'(last_acc), 8'h00);
        cyc(1'b0, 4'h0, 4'h0, 1'b0);
        #1;
        chk("bp_p_held", p, 8'h24);
        chk("bp_in_ready_held", 8'(in_ready), 8'h00);
        cyc(1'b0, 4'h0, 4'h0, 1'b1);
        #1;
        chk("bp_in_ready_back", 8'(in_ready), 8'h01);
        chk("bp_p_second", p, 8'h1E);
        cyc(1'b0, 4'h0, 4'h0, 1'b1);
        #1;
        chk("bp_empty", 8'(sb.size()), 8'd0);
        chk("bp_busy", 8'(busy), 8'h00);

        // Reset mid-flight discards both pairs
        cyc(1'b1, 4'd5, 4'd5, 1'b0);
        cyc(1'b1, 4'd7, 4'd3, 1'b0);
        in_valid = 1'b0;
        #2 R_n = 1'b0;
        #1;
        chk("midrst_out_valid", 8'(out_valid), 8'h00);
        chk("midrst_busy", 8'(busy), 8'h00);
        chk("midrst_in_ready", 8'(in_ready), 8'h01);
        chk("midrst_p", p, 8'h00);
        #3 R_n = 1'b1;
        sb.delete();
        repeat (3) begin
            cyc(1'b0, 4'hA, 4'hB, 1'b1);
            #1 chk("midrst_quiet", 8'(out_valid), 8'h00);
        end

        // Exhaustive with random valid/ready
        pops   = 0;
        idx    = 0;
        budget = 0;
        while (idx < 256 && budget < 5000) begin
            cyc(1'($urandom_range(0, 1)), 4'(idx >> 4), 4'(idx), 1'($urandom_range(0, 1)));
            if (last_acc) idx++;
            budget++;
        end
        budget = 0;
        while (sb.size() != 0 && budget < 20) begin
            cyc(1'b0, 4'h0, 4'h0, 1'b1);
            budget++;
        end
        #1;
        checks++;
        assert (pops == 256) else begin
            failures++;
            $error("FAIL exh_count observed=%0d expected=256", pops);
        end
        chk("exh_sb_empty", 8'(sb.size()), 8'd0);
        chk("exh_busy", 8'(busy), 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
